// File: rtl/vecmac_ctrl.sv
// vecmac_ctrl: job sequencer for the int8 vector-MAC datapath.
// Walks the rows of a job, issues lane-wide operand reads, produces the accumulator
// in_valid stream delayed by PIPE_LAT, and holds each row result in a valid/ready register.
// Optional build macro: VECMAC_CTRL_PERF_EN adds the perf_busy / perf_stall cycle counters.
//
// state | meaning
// IDLE  | waiting for start; idle=1
// ISSUE | one operand read per cycle, beats 0..BEATS-1 of the current row
// DRAIN | reads finished, waiting for acc_result_valid
// HOLD  | res_valid high until res_ready
// DONE  | single cycle, done=1
module vecmac_ctrl #(
  parameter int LANES    = 4,
  parameter int ELEMS    = 1000,
  parameter int PIPE_LAT = 3,
  parameter int ADDR_W   = 16,
  parameter int ROW_W    = 8,
  localparam int BEATS   = (ELEMS + LANES - 1) / LANES,
  localparam int STAGES  = (LANES < 4) ? 2 : $clog2(LANES),
  localparam int W_ACC   = 16 + STAGES + $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              idle,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              acc_in_valid,
  output logic              acc_rst,
  input  logic              acc_result_valid,
  input  logic [W_ACC-1:0]  acc_final_sum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W_ACC-1:0]  res_data,
  output logic [ROW_W-1:0]  res_row
`ifdef VECMAC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall
`endif
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ROW_W-1:0]    num_rows_q, num_rows_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;   // a_base + row*BEATS, advanced per row
  logic [ADDR_W-1:0]   b_base_q, b_base_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0]   rd_addr_b_q, rd_addr_b_d;
  logic [PIPE_LAT-1:0] pipe_q, pipe_d;
  logic [PIPE_LAT:0]   pipe_ext;
  logic                idle_q, idle_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                acc_rst_q, acc_rst_d;
  logic                res_valid_q, res_valid_d;
  logic [W_ACC-1:0]    res_data_q, res_data_d;
  logic [ROW_W-1:0]    res_row_q, res_row_d;
  logic                start_acc;

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      row_q       <= '0;
      num_rows_q  <= '0;
      row_addr_q  <= '0;
      b_base_q    <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      pipe_q      <= '0;
      idle_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_rst_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      row_q       <= row_d;
      num_rows_q  <= num_rows_d;
      row_addr_q  <= row_addr_d;
      b_base_q    <= b_base_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      pipe_q      <= pipe_d;
      idle_q      <= idle_d;
      done_q      <= done_d;
      err_q       <= err_d;
      acc_rst_q   <= acc_rst_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_row_q   <= res_row_d;
    end
  end

  // Next-state, address generation and result capture.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    row_d       = row_q;
    num_rows_d  = num_rows_q;
    row_addr_d  = row_addr_q;
    b_base_d    = b_base_q;
    rd_en_d     = 1'b0;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    err_d       = err_q;
    acc_rst_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_row_d   = res_row_q;
    start_acc   = 1'b0;

    if (abort) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      acc_rst_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_acc  = 1'b1;
            err_d      = 1'b0;
            num_rows_d = num_rows;
            b_base_d   = b_base;
            row_d      = '0;
            beat_d     = '0;
            row_addr_d = a_base;
            if (num_rows == '0) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_ISSUE;
              rd_en_d     = 1'b1;
              rd_addr_a_d = a_base;
              rd_addr_b_d = b_base;
            end
          end
        end
        S_ISSUE: begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DRAIN;
          end else begin
            beat_d      = beat_q + BEAT_W'(1);
            rd_en_d     = 1'b1;
            rd_addr_a_d = row_addr_q + ADDR_W'(beat_d);
            rd_addr_b_d = b_base_q + ADDR_W'(beat_d);
          end
        end
        S_DRAIN: begin
          if (acc_result_valid) begin
            res_data_d  = acc_final_sum;
            res_row_d   = row_q;
            res_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            if (row_q == num_rows_q - ROW_W'(1)) begin
              state_d = S_DONE;
            end else begin
              // Next row starts only after the handshake, so rows never overlap.
              row_d       = row_q + ROW_W'(1);
              beat_d      = '0;
              row_addr_d  = row_addr_q + ADDR_W'(BEATS);
              rd_en_d     = 1'b1;
              rd_addr_a_d = row_addr_d;
              rd_addr_b_d = b_base_q;
              state_d     = S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // A result arriving when none is expected is dropped but flagged; this outranks the
    // clear from a start accepted in the same cycle.
    if (acc_result_valid && (state_q != S_DRAIN)) begin
      err_d = 1'b1;
    end
  end

  // Status flags follow the next state so they line up with the registered state.
  always_comb begin
    idle_d   = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
    pipe_ext = {pipe_q, rd_en_q};
    pipe_d   = abort ? '0 : pipe_ext[PIPE_LAT-1:0];
  end

  assign idle         = idle_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rd_en        = rd_en_q;
  assign rd_addr_a    = rd_addr_a_q;
  assign rd_addr_b    = rd_addr_b_q;
  assign acc_in_valid = pipe_q[PIPE_LAT-1];
  assign acc_rst      = acc_rst_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_row      = res_row_q;

`ifdef VECMAC_CTRL_PERF_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_q, stall_d;

  // Saturating busy/stall counters, cleared by an accepted start.
  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (start_acc) begin
      busy_d  = '0;
      stall_d = '0;
    end else begin
      if (!idle_q && (busy_q != '1)) begin
        busy_d = busy_q + 32'd1;
      end
      if ((state_q == S_HOLD) && !res_ready && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_vecmac_ctrl.sv
// Directed bench for vecmac_ctrl with LANES=4, ELEMS=16 (BEATS=4), PIPE_LAT=3.
// A small behavioural accumulator turns the read stream into results from bench memories.
module tb_vecmac_ctrl;
  localparam int LANES = 4;
  localparam int BEATS = 4;
  localparam int W_ACC = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        num_rows = '0;
  logic [15:0]       a_base = '0;
  logic [15:0]       b_base = '0;
  logic              idle, done, err, rd_en, acc_in_valid, acc_rst, res_valid;
  logic [15:0]       rd_addr_a, rd_addr_b;
  logic              acc_result_valid;
  logic [W_ACC-1:0]  acc_final_sum;
  logic              res_ready = 1'b1;
  logic [W_ACC-1:0]  res_data;
  logic [7:0]        res_row;
`ifdef VECMAC_CTRL_PERF_EN
  logic [31:0]       perf_busy, perf_stall;
`endif

  vecmac_ctrl #(.LANES(4), .ELEMS(16), .PIPE_LAT(3), .ADDR_W(16), .ROW_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_rows(num_rows),
    .a_base(a_base), .b_base(b_base), .idle(idle), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .acc_in_valid(acc_in_valid), .acc_rst(acc_rst),
    .acc_result_valid(acc_result_valid), .acc_final_sum(acc_final_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row)
`ifdef VECMAC_CTRL_PERF_EN
    , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Operand memories: every lane of a word holds the same element value.
  int a_mem [256];
  int b_mem [256];

  // Accumulator model: products queued at the read, summed on acc_in_valid,
  // result presented the cycle after the last partial sum.
  int   prod_q [$];
  int   acc_sum = 0;
  int   acc_cnt = 0;
  logic acc_fire = 1'b0;
  logic model_valid = 1'b0;
  logic spur = 1'b0;
  logic [W_ACC-1:0] model_sum = '0;

  assign acc_result_valid = model_valid | spur;
  assign acc_final_sum    = model_sum;

  always @(negedge clk) begin
    model_valid = 1'b0;
    if (rst || acc_rst) begin
      prod_q.delete();
      acc_sum  = 0;
      acc_cnt  = 0;
      acc_fire = 1'b0;
    end else begin
      if (acc_fire) begin
        model_valid = 1'b1;
        model_sum   = W_ACC'(acc_sum);
        acc_fire    = 1'b0;
        acc_sum     = 0;
        acc_cnt     = 0;
      end
      if (rd_en) prod_q.push_back(LANES * a_mem[rd_addr_a[7:0]] * b_mem[rd_addr_b[7:0]]);
      if (acc_in_valid && prod_q.size() > 0) begin
        acc_sum += prod_q.pop_front();
        acc_cnt++;
        if (acc_cnt == BEATS) acc_fire = 1'b1;
      end
    end
  end

  // Per-job observations.
  logic [W_ACC-1:0] res_d [8];
  logic [7:0]       res_r [8];
  logic [15:0]      first_addr [8];
  int res_n, addr_n, done_cnt, rd_cnt;

  task automatic run_job(input logic [7:0] rows, input logic [15:0] ab, input logic [15:0] bb,
                         input int budget);
    logic prev_rd;
    res_n = 0; addr_n = 0; done_cnt = 0; rd_cnt = 0; prev_rd = 1'b0;
    @(negedge clk);
    num_rows = rows; a_base = ab; b_base = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rd_en) begin
        rd_cnt++;
        if (!prev_rd && addr_n < 8) begin
          first_addr[addr_n] = rd_addr_a;
          addr_n++;
        end
      end
      prev_rd = rd_en;
      if (res_valid && res_ready && res_n < 8) begin
        res_d[res_n] = res_data;
        res_r[res_n] = res_row;
        res_n++;
      end
      if (done) begin
        done_cnt++;
        break;
      end
      @(negedge clk);
    end
    check("job_done", done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_rst, n_done, n_aiv, n_rd;
    for (int i = 0; i < 256; i++) begin a_mem[i] = 0; b_mem[i] = 0; end
    for (int i = 0; i < 4; i++) begin
      a_mem[8'h10 + i] = 1;
      b_mem[8'h40 + i] = 2;
      b_mem[8'h60 + i] = 1;
      for (int r = 0; r < 3; r++) a_mem[8'h20 + 4 * r + i] = r + 1;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_aiv", acc_in_valid, 0);
    check("rst_acc_rst", acc_rst, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_row", res_row, 0);
    check("rst_addr_a", rd_addr_a, 0);
    check("rst_addr_b", rd_addr_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single row, A=1s, B=2s: cycle-accurate timeline
    num_rows = 8'd1; a_base = 16'h10; b_base = 16'h40; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("s1_rd_en", rd_en, 1);
      check("s1_addr_a", rd_addr_a, 32'h10 + c - 1);
      check("s1_addr_b", rd_addr_b, 32'h40 + c - 1);
    end
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      check("s1_rd_off", rd_en, 0);
      check("s1_aiv", acc_in_valid, (c <= 7) ? 1 : 0);
      check("s1_rv_low", res_valid, 0);
    end
    @(negedge clk);
    check("s1_res_valid", res_valid, 1);
    check("s1_res_data", res_data, 32);
    check("s1_res_row", res_row, 0);
    check("s1_no_done", done, 0);
    @(negedge clk);
    check("s1_done", done, 1);
    check("s1_rv_clr", res_valid, 0);
    @(negedge clk);
    check("s1_idle", idle, 1);
    check("s1_done_pulse", done, 0);

    // Three rows, row r = r+1, B=1s
    run_job(8'd3, 16'h20, 16'h60, 200);
    check("s2_res_n", res_n, 3);
    check("s2_rows_rd", rd_cnt, 12);
    for (int r = 0; r < 3; r++) begin
      check("s2_data", res_d[r], 16 * (r + 1));
      check("s2_row", res_r[r], r);
      check("s2_row_addr", first_addr[r], 32'h20 + 4 * r);
    end

    // Back-pressure: res_ready low 5 cycles in HOLD
    @(negedge clk);
    res_ready = 1'b0;
    num_rows = 8'd1; a_base = 16'h10; b_base = 16'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("s3_rv_cycle", cyc, 9);
    for (int i = 0; i < 5; i++) begin
      check("s3_hold_valid", res_valid, 1);
      check("s3_hold_data", res_data, 32);
      check("s3_hold_rd", rd_en, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("s3_done", done, 1);
    @(negedge clk);
`ifdef VECMAC_CTRL_PERF_EN
    check("s3_perf_stall", perf_stall, 5);
    check("s3_perf_busy", perf_busy, 15);
`endif
    check("s3_idle", idle, 1);

    // Abort in ISSUE cycle 3
    num_rows = 8'd1; a_base = 16'h10; b_base = 16'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s4_idle", idle, 1);
    check("s4_rd_en", rd_en, 0);
    check("s4_acc_rst", acc_rst, 1);
    check("s4_no_done", done, 0);
    n_rst = 0; n_done = 0; n_aiv = 0; n_rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_rst += int'(acc_rst);
      n_done += int'(done);
      n_aiv += int'(acc_in_valid);
      n_rd += int'(rd_en);
    end
    check("s4_rst_once", n_rst, 0);
    check("s4_done_none", n_done, 0);
    check("s4_aiv_none", n_aiv, 0);
    check("s4_rd_none", n_rd, 0);
    run_job(8'd1, 16'h10, 16'h40, 100);
    check("s4_rerun_data", res_d[0], 32);
    run_job(8'd2, 16'h20, 16'h60, 200);
    check("s4_rerun_r0", res_d[0], 16);
    check("s4_rerun_r1", res_d[1], 32);

    // Zero rows: done one cycle after start, no reads
    @(negedge clk);
    run_job(8'd0, 16'h10, 16'h40, 20);
    check("s5_rd_cnt", rd_cnt, 0);
    @(negedge clk);
    check("s5_idle", idle, 1);

    // Spurious result in IDLE sets err; next accepted start clears it
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("s6_err_set", err, 1);
    @(negedge clk);
    check("s6_err_sticky", err, 1);
    run_job(8'd0, 16'h10, 16'h40, 20);
    check("s6_err_clr", err, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
